// File: rtl/cluster_step_sequencer.sv
// Step sequencer for a combinational BDD output-bit cluster: accept a vector, hold it for a settle window, capture the result.
// Optional feature macro: STEP_FEEDBACK_EN (feeds the low STATE_W bits of the last result back into cl_i when in_fb is set).
module cluster_step_sequencer #(
  parameter int IN_W          = 1894,
  parameter int OUT_W         = 128,
  parameter int STATE_W       = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_vec,
  input  logic             i_in_fb,
  output logic [IN_W-1:0]  o_cl_i,
  input  logic [OUT_W-1:0] i_cl_o,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_vec,
  output logic             o_busy,
  output logic [31:0]      o_step_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_cnt;
  logic [IN_W-1:0]  r_clI;
  logic [OUT_W-1:0] r_outVec;
  logic [31:0]      r_stepCnt;
  logic [IN_W-1:0]  w_nextClI;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_inReady;
  logic             w_outValid;
  logic             w_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        w_busy = 1'b1;
        if (r_cnt == 8'd0) begin
          w_capture   = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_busy     = 1'b1;
        w_outValid = 1'b1;
        if (i_out_ready) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

`ifdef STEP_FEEDBACK_EN
  // Low state bits come from the last captured result so the cone can iterate on itself.
  always_comb begin
    w_nextClI = i_in_vec;
    if (i_in_fb) w_nextClI[STATE_W-1:0] = r_outVec[STATE_W-1:0];
  end
`else
  logic w_unusedFb;
  assign w_unusedFb = i_in_fb;
  assign w_nextClI  = i_in_vec;
`endif

  // cl_i is only rewritten on acceptance so the cone stays quiet between steps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= 8'd0;
      r_clI     <= '0;
      r_outVec  <= '0;
      r_stepCnt <= 32'd0;
    end else begin
      if (w_accept) begin
        r_clI <= w_nextClI;
        r_cnt <= SETTLE_LOAD;
      end else if (r_state == SETTLE && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_capture) r_outVec  <= i_cl_o;
      if (w_release) r_stepCnt <= r_stepCnt + 32'd1;
    end
  end

  assign o_in_ready  = w_inReady;
  assign o_out_valid = w_outValid;
  assign o_busy      = w_busy;
  assign o_cl_i      = r_clI;
  assign o_out_vec   = r_outVec;
  assign o_step_cnt  = r_stepCnt;

endmodule

// File: tb/tb_cluster_step_sequencer.sv
// Self-checking bench for cluster_step_sequencer with a behavioural step model and a stand-in cluster cone.
module tb_cluster_step_sequencer;

  localparam int IN_W          = 1894;
  localparam int OUT_W         = 128;
  localparam int STATE_W       = 64;
  localparam int SETTLE_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [IN_W-1:0]  inVec;
  logic             inFb;
  logic [IN_W-1:0]  clI;
  logic [OUT_W-1:0] clO;
  logic             outValid;
  logic             outReady;
  logic [OUT_W-1:0] outVec;
  logic             busy;
  logic [31:0]      stepCnt;

  int               checks = 0;
  int               errors = 0;
  logic [OUT_W-1:0] modelLast;
  logic [31:0]      modelSteps;

  always #5 clk = ~clk;

  cluster_step_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .STATE_W(STATE_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_in_vec(inVec), .i_in_fb(inFb), .o_cl_i(clI), .i_cl_o(clO),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_vec(outVec),
    .o_busy(busy), .o_step_cnt(stepCnt)
  );

  // Stand-in cluster: low 128 input bits xor top 128 input bits.
  function automatic logic [OUT_W-1:0] cone(input logic [IN_W-1:0] v);
    return v[OUT_W-1:0] ^ v[IN_W-1 -: OUT_W];
  endfunction

  assign clO = cone(clI);

  function automatic logic [IN_W-1:0] randVec();
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < IN_W; k += 32) v = (v << 32) | IN_W'($urandom);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // One complete step: offer vec, track settle, hold result for holdCycles with in_valid asserted, then consume.
  task automatic applyStimulus(input logic [IN_W-1:0] vec, input logic fb, input int holdCycles);
    logic [IN_W-1:0]  expCl;
    logic [OUT_W-1:0] expOut;
    int               lat;
    bit               seen;
    @(negedge clk);
    checkOutput("in_ready_idle", IN_W'(inReady), IN_W'(1));
    inValid = 1'b1;
    inVec   = vec;
    inFb    = fb;
    expCl   = vec;
`ifdef STEP_FEEDBACK_EN
    if (fb) expCl[STATE_W-1:0] = modelLast[STATE_W-1:0];
`endif
    expOut = cone(expCl);
    @(negedge clk);
    inValid = 1'b0;
    inVec   = randVec();
    inFb    = 1'($urandom);
    checkOutput("cl_i_drive", clI, expCl);
    lat  = 1;
    seen = 1'b0;
    while (lat <= 64 && !seen) begin
      if (outValid === 1'b1) begin
        seen = 1'b1;
      end else begin
        checkOutput("busy_settle", IN_W'({busy, inReady}), IN_W'(2'b10));
        outReady = 1'($urandom);
        @(negedge clk);
        lat++;
      end
    end
    outReady = 1'b0;
    checkOutput("out_latency", IN_W'(seen ? lat : 0), IN_W'(SETTLE_CYCLES + 1));
    checkOutput("out_vec_capture", IN_W'(outVec), IN_W'(expOut));
    inValid = 1'b1;
    for (int c = 0; c < holdCycles; c++) begin
      inVec = randVec();
      @(negedge clk);
    end
    checkOutput("hold_in_ready", IN_W'(inReady), IN_W'(0));
    checkOutput("hold_out_valid", IN_W'(outValid), IN_W'(1));
    checkOutput("hold_out_vec", IN_W'(outVec), IN_W'(expOut));
    checkOutput("hold_cl_i", clI, expCl);
    checkOutput("hold_step_cnt", IN_W'(stepCnt), IN_W'(modelSteps));
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    outReady   = 1'b0;
    modelSteps = modelSteps + 32'd1;
    modelLast  = expOut;
    checkOutput("release_out_valid", IN_W'({outValid, busy, inReady}), IN_W'(3'b001));
    checkOutput("release_step_cnt", IN_W'(stepCnt), IN_W'(modelSteps));
    checkOutput("idle_cl_i_kept", clI, expCl);
    checkOutput("idle_out_vec_kept", IN_W'(outVec), IN_W'(expOut));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_flags"}, IN_W'({inReady, outValid, busy}), IN_W'(3'b100));
    checkOutput({tag, "_cl_i"}, clI, '0);
    checkOutput({tag, "_out_vec"}, IN_W'(outVec), '0);
    checkOutput({tag, "_step_cnt"}, IN_W'(stepCnt), '0);
  endtask

  initial begin
    logic [IN_W-1:0] v;
    rst = 1'b1; inValid = 1'b0; inVec = '0; inFb = 1'b0; outReady = 1'b0;
    modelLast = '0; modelSteps = 32'd0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Reset while the settle counter is at 2: step is abandoned.
    @(negedge clk);
    inValid = 1'b1; inVec = randVec();
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("mid_settle_reset");
    rst = 1'b0;
    repeat (SETTLE_CYCLES + 2) @(negedge clk);
    checkOutput("no_late_capture", IN_W'({outValid, busy}), '0);

    // First step after reset with feedback requested.
    applyStimulus(randVec(), 1'b1, 1);

    v = '0; v[72] = 1'b1;
    applyStimulus(v, 1'b0, 2);
    checkOutput("basic_bit72", IN_W'(outVec), IN_W'(v[127:0]));

    // Backpressure: result held for 20 cycles while in_valid stays high.
    applyStimulus(randVec(), 1'b0, 20);

    v = '0; v[7:0] = 8'hA5;
    applyStimulus(v, 1'b0, 0);
    applyStimulus('0, 1'b1, 0);
`ifdef STEP_FEEDBACK_EN
    checkOutput("feedback_a5", IN_W'(clI[63:0]), IN_W'(64'hA5));
`else
    checkOutput("feedback_off", IN_W'(clI[63:0]), '0);
`endif

    for (int s = 0; s < 6; s++) applyStimulus(randVec(), 1'($urandom), int'($urandom_range(0, 5)));

    // Counter wrap.
    @(negedge clk);
    force dut.r_stepCnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_stepCnt;
    modelSteps = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("preload_step_cnt", IN_W'(stepCnt), IN_W'(modelSteps));
    applyStimulus(randVec(), 1'b0, 0);
    checkOutput("wrap_step_cnt", IN_W'(stepCnt), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
